// File: rtl/hack_mem_pkg.sv
// Shared constants, region decode and screen-write record for the Hack data memory.
package hack_mem_pkg;

    localparam int HACK_DW = 16;
    localparam int HACK_AW = 15;

    localparam logic [HACK_AW-1:0] RAM_BASE = 15'h0000;
    localparam logic [HACK_AW-1:0] SCR_BASE = 15'h4000;
    localparam logic [HACK_AW-1:0] KBD_ADDR = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_e;

    typedef struct packed {
        logic [12:0]        addr;
        logic [HACK_DW-1:0] data;
    } scr_wr_t;

    // Only the top two address bits pick the region; the I/O page holds a single register.
    function automatic region_e decode_region(input logic [HACK_AW-1:0] addr);
        region_e r;
        unique case (addr[14:13])
            2'b00, 2'b01: r = REG_RAM;
            2'b10:        r = REG_SCR;
            default:      r = (addr == KBD_ADDR) ? REG_KBD : REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hack_dmem_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared too so the head reads zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hack_dmem.sv
// Hack CPU data memory: RAM, screen shadow with display write FIFO, keyboard register, CPU stall.
// Optional out-of-range access trap enabled with HACK_DMEM_OOR_TRAP_EN.
module hack_dmem
    import hack_mem_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 15,
    parameter int RAM_WORDS  = 16384,
    parameter int SCR_WORDS  = 8192,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic          en25m,
    input  logic [AW-1:0] addressM,
    input  logic          writeM,
    input  logic [DW-1:0] outM,
    output logic [DW-1:0] inM,
    output logic          cpu_en,
    input  logic          kbd_valid,
    input  logic [DW-1:0] kbd_code,
    output logic          scr_valid,
    output logic [12:0]   scr_addr,
    output logic [DW-1:0] scr_data,
    input  logic          scr_ready
`ifdef HACK_DMEM_OOR_TRAP_EN
    ,
    output logic          oor_err,
    output logic [AW-1:0] oor_addr
`endif
);

    localparam int RIW = $clog2(RAM_WORDS);

    logic [DW-1:0] ram_mem [RAM_WORDS];
    logic [DW-1:0] scr_mem [SCR_WORDS];

    region_e       region;
    logic [RIW-1:0] ram_idx;
    logic [12:0]   scr_idx;
    logic          scr_hit;
    logic          fifo_full, fifo_empty;
    logic          stall, wr_commit, push, pop;
    scr_wr_t       fifo_din, fifo_dout;
    logic [DW-1:0] inm_q, inm_d;
    logic [DW-1:0] kbd_q, kbd_d;

    assign region  = decode_region(addressM);
    assign ram_idx = addressM[RIW-1:0];
    assign scr_idx = addressM[12:0];
    assign scr_hit = (region == REG_SCR);

    // full is the registered count, so a pop in this same cycle cannot release the stall.
    assign stall     = writeM & scr_hit & fifo_full;
    assign cpu_en    = en25m & ~stall;
    assign wr_commit = cpu_en & writeM & ~rst;
    assign push      = wr_commit & scr_hit;

    assign fifo_din  = {addressM[12:0], outM};
    assign scr_valid = ~fifo_empty;
    assign pop       = scr_valid & scr_ready;
    assign scr_addr  = fifo_dout.addr;
    assign scr_data  = fifo_dout.data;

    sync_fifo #(
        .WIDTH ($bits(scr_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_scr_fifo (
        .clk   (clk50m),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        inm_d = inm_q;
        if (!en25m) begin
            unique case (region)
                REG_RAM:  inm_d = ram_mem[ram_idx];
                REG_SCR:  inm_d = scr_mem[scr_idx];
                REG_KBD:  inm_d = kbd_q;
                default:  inm_d = '0;
            endcase
        end
    end

    always_comb begin
        kbd_d = kbd_q;
        if (kbd_valid) begin
            kbd_d = kbd_code;
        end
    end

    always_ff @(posedge clk50m) begin
        if (rst) begin
            inm_q <= '0;
            kbd_q <= '0;
        end else begin
            inm_q <= inm_d;
            kbd_q <= kbd_d;
        end
    end

    assign inM = inm_q;

    // Array contents survive reset; only committed phase-B writes touch them.
    always_ff @(posedge clk50m) begin
        if (wr_commit && region == REG_RAM) begin
            ram_mem[ram_idx] <= outM;
        end
        if (push) begin
            scr_mem[scr_idx] <= outM;
        end
    end

`ifdef HACK_DMEM_OOR_TRAP_EN
    logic          oor_hit;
    logic          oor_err_q, oor_err_d;
    logic [AW-1:0] oor_addr_q, oor_addr_d;

    assign oor_hit = cpu_en & ((region == REG_NONE) | ((region == REG_KBD) & writeM));

    always_comb begin
        oor_err_d  = oor_err_q;
        oor_addr_d = oor_addr_q;
        if (oor_hit && !oor_err_q) begin
            oor_err_d  = 1'b1;
            oor_addr_d = addressM;
        end
    end

    always_ff @(posedge clk50m) begin
        if (rst) begin
            oor_err_q  <= 1'b0;
            oor_addr_q <= '0;
        end else begin
            oor_err_q  <= oor_err_d;
            oor_addr_q <= oor_addr_d;
        end
    end

    assign oor_err  = oor_err_q;
    assign oor_addr = oor_addr_q;
`endif

endmodule

// File: tb/tb_hack_dmem.sv
// Self-checking bench for hack_dmem against a behavioural memory/FIFO model.
module tb_hack_dmem;

    localparam int FIFO_DEPTH = 4;

    logic        clk50m;
    logic        rst;
    logic        en25m;
    logic [14:0] addressM;
    logic        writeM;
    logic [15:0] outM;
    logic [15:0] inM;
    logic        cpu_en;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        scr_valid;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ready;
`ifdef HACK_DMEM_OOR_TRAP_EN
    logic        oor_err;
    logic [14:0] oor_addr;
    logic        oor_err_m;
    logic [14:0] oor_addr_m;
`endif

    hack_dmem #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .en25m     (en25m),
        .addressM  (addressM),
        .writeM    (writeM),
        .outM      (outM),
        .inM       (inM),
        .cpu_en    (cpu_en),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .scr_valid (scr_valid),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .scr_ready (scr_ready)
`ifdef HACK_DMEM_OOR_TRAP_EN
        ,
        .oor_err   (oor_err),
        .oor_addr  (oor_addr)
`endif
    );

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kbd_m;
    logic [28:0] exp_q [$];
    logic        rand_ready = 1'b0;

    function automatic logic ref_known(input logic [14:0] a);
        if (a < 15'h4000) return ram_m.exists(int'(a));
        if (a < 15'h6000) return scr_m.exists(int'(a - 15'h4000));
        return 1'b1;
    endfunction

    function automatic logic [15:0] ref_read(input logic [14:0] a);
        if (a < 15'h4000) return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'h0;
        if (a < 15'h6000) return scr_m.exists(int'(a - 15'h4000)) ? scr_m[int'(a - 15'h4000)] : 16'h0;
        if (a == 15'h6000) return kbd_m;
        return 16'h0;
    endfunction

    // Display side: head must match the oldest committed screen write; a pop retires it.
    always @(negedge clk50m) begin
        if (!rst) begin
            checks++;
            if (scr_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL scr_valid got=%b exp=%b t=%0t", scr_valid, exp_q.size() != 0, $time);
            end else if (scr_valid) begin
                checks++;
                if ({scr_addr, scr_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL scr_head got=%h/%h exp=%h/%h", scr_addr, scr_data,
                             exp_q[0][28:16], exp_q[0][15:0]);
                end
                if (scr_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One CPU step: phase A read, phase B write, retrying phase pairs while stalled.
    task automatic cpu_step(input logic [14:0] a, input logic w, input logic [15:0] d,
                            input logic kv, input logic [15:0] kc, output int stalls);
        logic [15:0] exp_rd;
        logic        known, is_scr, exp_ce, done;
        stalls = 0;
        done   = 1'b0;
        exp_rd = ref_read(a);
        known  = ref_known(a);
        is_scr = (a >= 15'h4000) && (a < 15'h6000);
        addressM = a; writeM = w; outM = d; kbd_valid = kv; kbd_code = kc; en25m = 1'b0;
        if (rand_ready) scr_ready = 1'($urandom_range(0, 1));
        @(posedge clk50m); #1;
        kbd_valid = 1'b0;
        if (kv) kbd_m = kc;
        for (int tries = 0; tries < 100 && !done; tries++) begin
            en25m = 1'b1;
            if (rand_ready) scr_ready = 1'($urandom_range(0, 1));
            #1;
            if (known) begin
                checks++;
                if (inM !== exp_rd) begin
                    errors++;
                    $display("FAIL inM addr=%h got=%h exp=%h", a, inM, exp_rd);
                end
            end
            exp_ce = !(w && is_scr && exp_q.size() == FIFO_DEPTH);
            checks++;
            if (cpu_en !== exp_ce) begin
                errors++;
                $display("FAIL cpu_en addr=%h got=%b exp=%b", a, cpu_en, exp_ce);
            end
            @(posedge clk50m); #1;
            if (exp_ce) begin
                done = 1'b1;
                if (w && a < 15'h4000) ram_m[int'(a)] = d;
                if (w && is_scr) begin
                    scr_m[int'(a[12:0])] = d;
                    exp_q.push_back({a[12:0], d});
                end
`ifdef HACK_DMEM_OOR_TRAP_EN
                if ((a > 15'h6000 || (w && a == 15'h6000)) && !oor_err_m) begin
                    oor_err_m  = 1'b1;
                    oor_addr_m = a;
                end
`endif
            end else begin
                stalls++;
                en25m = 1'b0;
                if (rand_ready) scr_ready = 1'($urandom_range(0, 1));
                @(posedge clk50m); #1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL stall_timeout addr=%h got=stalled exp=commit", a);
        end
        en25m  = 1'b0;
        writeM = 1'b0;
`ifdef HACK_DMEM_OOR_TRAP_EN
        checks++;
        if (oor_err !== oor_err_m || (oor_err_m && oor_addr !== oor_addr_m)) begin
            errors++;
            $display("FAIL oor got=%b/%h exp=%b/%h", oor_err, oor_addr, oor_err_m, oor_addr_m);
        end
`endif
    endtask

    task automatic apply_reset();
        rst = 1'b1; en25m = 1'b0; writeM = 1'b0; kbd_valid = 1'b0;
        exp_q.delete();
        kbd_m = 16'h0;
`ifdef HACK_DMEM_OOR_TRAP_EN
        oor_err_m  = 1'b0;
        oor_addr_m = 15'h0;
`endif
        @(posedge clk50m); #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (inM !== 16'h0 || scr_valid !== 1'b0 || scr_addr !== 13'h0 || scr_data !== 16'h0) begin
            errors++;
            $display("FAIL %s got inM=%h v=%b a=%h d=%h exp all zero", tag, inM, scr_valid, scr_addr, scr_data);
        end
        checks++;
        if (cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_cpu_en got=%b exp=0 (phase A)", tag, cpu_en);
        end
    endtask

    task automatic drain_fifo();
        scr_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk50m);
        #1;
        checks++;
        if (exp_q.size() != 0 || scr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got valid=%b pending=%0d exp 0/0", scr_valid, exp_q.size());
        end
    endtask

    task automatic test_reset();
        int s;
        apply_reset();
        check_reset_outputs("reset");
        cpu_step(15'h6000, 1'b0, 16'h0, 1'b0, 16'h0, s);
    endtask

    task automatic test_ram();
        int s;
        cpu_step(15'h0010, 1'b1, 16'h1234, 1'b0, 16'h0, s);
        cpu_step(15'h0010, 1'b0, 16'h0, 1'b0, 16'h0, s);
        cpu_step(15'h0020, 1'b1, 16'h1111, 1'b0, 16'h0, s);
        cpu_step(15'h0020, 1'b1, 16'h5678, 1'b0, 16'h0, s);  // same-step read sees 0x1111
        cpu_step(15'h0020, 1'b0, 16'h0, 1'b0, 16'h0, s);
        cpu_step(15'h3FFF, 1'b1, 16'hBEEF, 1'b0, 16'h0, s);
        cpu_step(15'h3FFF, 1'b0, 16'h0, 1'b0, 16'h0, s);
    endtask

    task automatic test_screen();
        int s;
        scr_ready = 1'b1;
        cpu_step(15'h4003, 1'b1, 16'hA5A5, 1'b0, 16'h0, s);
        checks++;
        if (scr_valid !== 1'b1 || scr_addr !== 13'h003 || scr_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL screen_push got v=%b a=%h d=%h exp 1/003/a5a5", scr_valid, scr_addr, scr_data);
        end
        cpu_step(15'h4003, 1'b0, 16'h0, 1'b0, 16'h0, s);
        cpu_step(15'h5FFF, 1'b1, 16'h0F0F, 1'b0, 16'h0, s);
        cpu_step(15'h5FFF, 1'b0, 16'h0, 1'b0, 16'h0, s);
        drain_fifo();
    endtask

    task automatic test_fifo_full();
        int s;
        scr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_step(15'h4010 + 15'(i), 1'b1, 16'h0100 + 16'(i), 1'b0, 16'h0, s);
            checks++;
            if (s != 0) begin
                errors++;
                $display("FAIL fifo_fill_%0d got stalls=%0d exp=0", i, s);
            end
        end
        fork
            cpu_step(15'h4014, 1'b1, 16'h0104, 1'b0, 16'h0, s);
            begin
                repeat (5) @(posedge clk50m);
                #1 scr_ready = 1'b1;
            end
        join
        checks++;
        if (s < 2) begin
            errors++;
            $display("FAIL fifo_stall got stalls=%0d exp>=2", s);
        end
        drain_fifo();
    endtask

    task automatic test_kbd();
        int s;
        cpu_step(15'h6000, 1'b0, 16'h0, 1'b1, 16'h0041, s);  // pulse during phase A read: old value
        cpu_step(15'h6000, 1'b0, 16'h0, 1'b0, 16'h0, s);
        cpu_step(15'h6000, 1'b1, 16'hFFFF, 1'b0, 16'h0, s);
        cpu_step(15'h6000, 1'b0, 16'h0, 1'b0, 16'h0, s);
        checks++;
        if (inM !== 16'h0041) begin
            errors++;
            $display("FAIL kbd_hold got=%h exp=0041", inM);
        end
        cpu_step(15'h6005, 1'b1, 16'h1234, 1'b0, 16'h0, s);
        cpu_step(15'h6005, 1'b0, 16'h0, 1'b0, 16'h0, s);
    endtask

    task automatic test_random();
        int s;
        logic [14:0] a;
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 15'h0100 + 15'($urandom_range(0, 7));
                4, 5, 6:    a = 15'h4100 + 15'($urandom_range(0, 7));
                7:          a = 15'h6000;
                8:          a = 15'h6001 + 15'($urandom_range(0, 15'h1FFE));
                default:    a = 15'h7FFF;
            endcase
            cpu_step(a, 1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 7) == 0),
                     16'($urandom), s);
        end
        rand_ready = 1'b0;
        drain_fifo();
    endtask

    task automatic test_reset_mid();
        int s;
        scr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_step(15'h4200 + 15'(i), 1'b1, 16'hC000 + 16'(i), 1'b0, 16'h0, s);
        end
        checks++;
        if (scr_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got=%b exp=1", scr_valid);
        end
        apply_reset();
        check_reset_outputs("reset_mid");
        cpu_step(15'h6000, 1'b0, 16'h0, 1'b0, 16'h0, s);
        cpu_step(15'h0010, 1'b0, 16'h0, 1'b0, 16'h0, s);
        checks++;
        if (inM !== 16'h1234) begin
            errors++;
            $display("FAIL ram_after_reset got=%h exp=1234", inM);
        end
        cpu_step(15'h4201, 1'b0, 16'h0, 1'b0, 16'h0, s);
        scr_ready = 1'b1;
    endtask

`ifdef HACK_DMEM_OOR_TRAP_EN
    task automatic test_oor();
        int s;
        cpu_step(15'h7000, 1'b1, 16'h1111, 1'b0, 16'h0, s);
        cpu_step(15'h6001, 1'b1, 16'h2222, 1'b0, 16'h0, s);
        checks++;
        if (oor_err !== 1'b1 || oor_addr !== 15'h7000) begin
            errors++;
            $display("FAIL oor_first got=%b/%h exp=1/7000", oor_err, oor_addr);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; en25m = 1'b0; addressM = '0; writeM = 1'b0; outM = '0;
        kbd_valid = 1'b0; kbd_code = '0; scr_ready = 1'b0;
        kbd_m = '0;
        @(posedge clk50m); #1;
        test_reset();
        test_ram();
        test_screen();
        test_fifo_full();
        test_kbd();
        test_random();
        test_reset_mid();
`ifdef HACK_DMEM_OOR_TRAP_EN
        test_oor();
`endif
        repeat (2) @(posedge clk50m);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
